vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pixel_tick.sv | 31 +++
 rtl/vga_sync_gen.sv | 91 +++++++++
 tb/tb_vga_sync_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decode helpers for the sync generator
// and the object generators that decode HCount/VCount.
package vga_timing_pkg;

    localparam int unsigned H_DISP  = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned V_DISP  = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;

    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W = 10;

    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [CNT_W-1:0] count_t;

    // Inclusive window [lo, lo+len-1], compared as unsigned 10-bit values.
    function automatic logic in_window(input count_t c, input int unsigned lo,
                                       input int unsigned len);
        return (c >= count_t'(lo)) && (c <= count_t'(lo + len - 1));
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: registered one-clock p_tick every CLK_DIV system clocks
// (CLK_DIV 1..16; with CLK_DIV=1 p_tick stays high after the first clock).
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;
    logic [3:0] div_next;

    always_comb begin
        div_next = (div == LAST) ? '0 : div + 4'd1;
    end

    // p_tick tracks the divider value being loaded, so it is high exactly while div == LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            div    <= div_next;
            p_tick <= (div_next == LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: HCount/VCount, active-low syncs, video_on and frame_start.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit frame_cnt output.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_DISP  = vga_timing_pkg::H_DISP,
    parameter int unsigned H_FP    = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_timing_pkg::H_BP,
    parameter int unsigned V_DISP  = vga_timing_pkg::V_DISP,
    parameter int unsigned V_FP    = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_timing_pkg::V_BP
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            p_tick,
    output logic [vga_timing_pkg::CNT_W-1:0] HCount,
    output logic [vga_timing_pkg::CNT_W-1:0] VCount,
    output logic                            hsync,
    output logic                            vsync,
    output logic                            video_on,
    output logic                            frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0]                      frame_cnt
`endif
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam count_t      H_LAST = count_t'(H_TOT - 1);
    localparam count_t      V_LAST = count_t'(V_TOT - 1);

    count_t h_next;
    count_t v_next;
    logic   h_end;
    logic   v_end;

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    always_comb begin
        h_end  = (HCount == H_LAST);
        v_end  = (VCount == V_LAST);
        h_next = h_end ? '0 : HCount + count_t'(1);
        v_next = VCount;
        if (h_end) begin
            v_next = v_end ? '0 : VCount + count_t'(1);
        end
    end

    // Decode uses the next-state counts so it lands in the same cycle as the counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HCount      <= '0;
            VCount      <= '0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (p_tick) begin
                HCount      <= h_next;
                VCount      <= v_next;
                hsync       <= in_window(h_next, H_DISP + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync       <= in_window(v_next, V_DISP + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                video_on    <= (h_next < count_t'(H_DISP)) && (v_next < count_t'(V_DISP));
                frame_start <= h_end && v_end;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (p_tick && h_end && v_end) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three configurations checked every clock
// against a counting model derived from pixel-tick arithmetic.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic       a_pt, a_hs, a_vs, a_von, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_pt, b_hs, b_vs, b_von, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_pt, c_hs, c_vs, c_von, c_fs;
    logic [9:0] c_h, c_v;
    logic [7:0] a_fc, b_fc, c_fc;

`ifndef VGA_FRAME_COUNT_EN
    assign a_fc = 8'd0;
    assign b_fc = 8'd0;
    assign c_fc = 8'd0;
`endif

    vga_sync_gen #(
        .CLK_DIV(2)
    ) dut_a (
        .clk(clk), .reset(reset), .p_tick(a_pt), .HCount(a_h), .VCount(a_v),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(3),
        .H_DISP(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_DISP(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk(clk), .reset(reset), .p_tick(b_pt), .HCount(b_h), .VCount(b_v),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(1),
        .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_c (
        .clk(clk), .reset(reset), .p_tick(c_pt), .HCount(c_h), .VCount(c_v),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .frame_start(c_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(c_fc)
`endif
    );

    typedef struct packed {
        logic       pt;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    obs_t qa[$], qb[$], qc[$];
    int unsigned n = 0;
    int errors = 0;
    int checks = 0;

    // Pixel advances seen after k clocks since reset release.
    function automatic int unsigned adv(input int unsigned k, input int unsigned d);
        if (k == 0) return 0;
        return (d == 1) ? k - 1 : k / d;
    endfunction

    function automatic obs_t model(input int unsigned k, input int unsigned d,
                                   input int unsigned hd, input int unsigned hf,
                                   input int unsigned hsw, input int unsigned hb,
                                   input int unsigned vd, input int unsigned vf,
                                   input int unsigned vsw, input int unsigned vb);
        obs_t e;
        int unsigned ht, vt, a, ap, h, v;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (k == 0) return e;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        a  = adv(k, d);
        ap = adv(k - 1, d);
        h  = a % ht;
        v  = (a / ht) % vt;
        e.pt  = (d == 1) || (k % d == d - 1);
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = !(h >= hd + hf && h < hd + hf + hsw);
        e.vs  = !(v >= vd + vf && v < vd + vf + vsw);
        e.von = (a > 0) && (h < hd) && (v < vd);
        e.fs  = (a != ap) && (a % (ht * vt) == 0);
`ifdef VGA_FRAME_COUNT_EN
        e.fc  = 8'((a / (ht * vt)) % 256);
`endif
        return e;
    endfunction

    function automatic obs_t mk(input logic pt, input logic [9:0] h, input logic [9:0] v,
                                input logic hs, input logic vs, input logic von,
                                input logic fs, input logic [7:0] fc);
        obs_t o;
        o.pt = pt; o.h = h; o.v = v; o.hs = hs; o.vs = vs;
        o.von = von; o.fs = fs; o.fc = fc;
        return o;
    endfunction

    task automatic compare(input string nm, input obs_t e, input obs_t g);
        checks++;
        if (e !== g) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s t=%0t got pt=%0b h=%0d v=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d expected pt=%0b h=%0d v=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d",
                         nm, $time, g.pt, g.h, g.v, g.hs, g.vs, g.von, g.fs, g.fc,
                         e.pt, e.h, e.v, e.hs, e.vs, e.von, e.fs, e.fc);
        end
    endtask

    function automatic obs_t exp_a(input int unsigned k);
        return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic obs_t exp_b(input int unsigned k);
        return model(k, 3, 20, 4, 6, 5, 10, 2, 2, 3);
    endfunction
    function automatic obs_t exp_c(input int unsigned k);
        return model(k, 1, 8, 2, 3, 2, 4, 1, 2, 1);
    endfunction

    // Stimulus side: push the expected post-edge state for every clock.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) n = 0;
            else       n = n + 1;
            qa.push_back(exp_a(n));
            qb.push_back(exp_b(n));
            qc.push_back(exp_c(n));
        end
    end

    // Monitor side: outputs are presented every clock; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (qa.size() != 0) compare("cfg_a", qa.pop_front(), mk(a_pt, a_h, a_v, a_hs, a_vs, a_von, a_fs, a_fc));
            if (qb.size() != 0) compare("cfg_b", qb.pop_front(), mk(b_pt, b_h, b_v, b_hs, b_vs, b_von, b_fs, b_fc));
            if (qc.size() != 0) compare("cfg_c", qc.pop_front(), mk(c_pt, c_h, c_v, c_hs, c_vs, c_von, c_fs, c_fc));
        end
    end

    // Assert reset between clock edges and check outputs clear before any edge.
    task automatic async_reset();
        @(negedge clk);
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        compare("async_rst_a", exp_a(0), mk(a_pt, a_h, a_v, a_hs, a_vs, a_von, a_fs, a_fc));
        compare("async_rst_b", exp_b(0), mk(b_pt, b_h, b_v, b_hs, b_vs, b_von, b_fs, b_fc));
        compare("async_rst_c", exp_c(0), mk(c_pt, c_h, c_v, c_hs, c_vs, c_von, c_fs, c_fc));
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        repeat (20000) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(300, 3000)) @(posedge clk);
            async_reset();
        end

        hit = 1'b0;
        for (int k = 0; k < 4000 && !hit; k++) begin
            @(negedge clk);
            hit = (b_h == 10'd12) && (b_v == 10'd7);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midframe_wait got no (12,7) within 4000 clks expected position reached");
        end
        async_reset();

        repeat (32000) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
